// File: rtl/instr_mem_responder.sv
// Instruction fetch responder with a byte-serial program loader.
// Fetches answer one cycle after acceptance; loads stall fetches.
module instr_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_instr,
  output logic        rsp_fault,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  input  logic        ld_end,
  output logic        ld_busy,
  output logic [15:0] ld_words,
  output logic        ld_overflow
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic {
    IDLE,
    LOAD
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [23:0]   asm_q, asm_d;
  logic [15:0]   words_q, words_d;
  logic          ovf_q, ovf_d;

  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_fault_q, rsp_fault_d;
  logic [31:0]   rsp_instr_q, rsp_instr_d;

  logic [31:0]   mem [DEPTH_WORDS];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;

  logic          fetch_acc;
  logic          fetch_fault;
  logic [AW-1:0] fetch_idx;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  assign ld_busy     = (state_q == LOAD);
  assign req_ready   = !ld_busy;
  assign ld_words    = words_q;
  assign ld_overflow = ovf_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_fault   = rsp_fault_q;
  assign rsp_instr   = rsp_instr_q;

  assign fetch_acc   = req_valid && req_ready;
  assign fetch_idx   = req_addr[AW+1:2];
  assign fetch_fault = (req_addr[1:0] != 2'b00)
                    || (|req_addr[31:AW+2]);

  always_comb begin
    rsp_valid_d = fetch_acc;
    rsp_fault_d = 1'b0;
    rsp_instr_d = NOP_INSTR;
    if (fetch_acc) begin
      if (fetch_fault) begin
        rsp_fault_d = 1'b1;
      end else begin
        rsp_instr_d = mem[fetch_idx];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    ptr_d      = ptr_q;
    asm_d      = asm_q;
    words_d    = words_q;
    ovf_d      = ovf_q;
    mem_we     = 1'b0;
    mem_waddr  = ptr_q;
    mem_wdata  = 32'h0;
    unique case (state_q)
      IDLE: begin
        if (ld_start) begin
          state_d    = LOAD;
          byte_idx_d = 2'd0;
          ptr_d      = '0;
          asm_d      = 24'h0;
          words_d    = 16'h0;
          ovf_d      = 1'b0;
        end
      end
      LOAD: begin
        if (ld_start) begin
          byte_idx_d = 2'd0;
          ptr_d      = '0;
          asm_d      = 24'h0;
          words_d    = 16'h0;
          ovf_d      = 1'b0;
        end else begin
          if (ld_valid) begin
            if (byte_idx_q == 2'd3) begin
              mem_we     = 1'b1;
              mem_wdata  = {ld_byte, asm_q};
              ptr_d      = ptr_q + 1'b1;
              words_d    = sat_inc(words_q);
              byte_idx_d = 2'd0;
              asm_d      = 24'h0;
              if (&ptr_q) begin
                ovf_d = 1'b1;
              end
            end else begin
              asm_d[{byte_idx_q, 3'b000} +: 8] = ld_byte;
              byte_idx_d = byte_idx_q + 2'd1;
            end
          end
          // asm is cleared per word, so unused upper lanes are zero
          if (ld_end) begin
            state_d = IDLE;
            if (byte_idx_d != 2'd0) begin
              mem_we    = 1'b1;
              mem_waddr = ptr_d;
              mem_wdata = {8'h00, asm_d};
              words_d   = sat_inc(words_d);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      byte_idx_q  <= 2'd0;
      ptr_q       <= '0;
      asm_q       <= 24'h0;
      words_q     <= 16'h0;
      ovf_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_instr_q <= NOP_INSTR;
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      ptr_q       <= ptr_d;
      asm_q       <= asm_d;
      words_q     <= words_d;
      ovf_q       <= ovf_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_fault_q <= rsp_fault_d;
      rsp_instr_q <= rsp_instr_d;
    end
  end

  // Program memory keeps its contents across reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Randomized bench for instr_mem_responder against a byte-count
// reference model, plus directed literal checks.
module tb_instr_mem_responder;

  localparam int D = 256;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_instr;
  logic        rsp_fault;
  logic        ld_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_byte = 8'h0;
  logic        ld_end = 1'b0;
  logic        ld_busy;
  logic [15:0] ld_words;
  logic        ld_overflow;

  instr_mem_responder #(
    .DEPTH_WORDS(D),
    .NOP_INSTR(NOP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_addr(req_addr),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_instr(rsp_instr),
    .rsp_fault(rsp_fault),
    .ld_start(ld_start),
    .ld_valid(ld_valid),
    .ld_byte(ld_byte),
    .ld_end(ld_end),
    .ld_busy(ld_busy),
    .ld_words(ld_words),
    .ld_overflow(ld_overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [31:0] m [D];
  bit          known [D];
  bit          in_load = 0;
  int          n = 0;
  int          words = 0;
  bit          ovf = 0;
  logic [7:0]  cur [4];
  bit          exp_valid = 0;
  bit          exp_fault = 0;
  logic [31:0] exp_instr = NOP;
  bit          exp_known = 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_word(input int idx, input logic [31:0] w);
    m[idx] = w;
    known[idx] = 1;
    if (words < 65535) words++;
  endtask

  initial begin
    for (int i = 0; i < D; i++) known[i] = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        exp_valid = 0; exp_fault = 0; exp_instr = NOP; exp_known = 1;
        in_load = 0; n = 0; words = 0; ovf = 0;
      end else begin
        exp_valid = req_valid && !in_load;
        exp_fault = 0; exp_instr = NOP; exp_known = 1;
        if (exp_valid) begin
          if (req_addr[1:0] != 2'b00 || req_addr[31:2] >= 30'(D)) begin
            exp_fault = 1;
          end else begin
            exp_instr = m[int'(req_addr[31:2])];
            exp_known = known[int'(req_addr[31:2])];
          end
        end
        if (ld_start) begin
          in_load = 1; n = 0; words = 0; ovf = 0;
        end else if (in_load) begin
          if (ld_valid) begin
            cur[n % 4] = ld_byte;
            n++;
            if (n % 4 == 0) begin
              model_word((n / 4 - 1) % D,
                         {cur[3], cur[2], cur[1], cur[0]});
              if ((n / 4) % D == 0) ovf = 1;
            end
          end
          if (ld_end) begin
            if (n % 4 != 0) begin
              logic [31:0] w;
              w = 32'h0;
              for (int k = 0; k < n % 4; k++) w[8*k +: 8] = cur[k];
              model_word((n / 4) % D, w);
            end
            in_load = 0;
          end
        end
      end
      #1;
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
      chk("rsp_fault", 32'(rsp_fault), 32'(exp_fault));
      if (exp_known) chk("rsp_instr", rsp_instr, exp_instr);
      chk("ld_busy", 32'(ld_busy), 32'(in_load));
      chk("req_ready", 32'(req_ready), 32'(!in_load));
      chk("ld_words", 32'(ld_words), 32'(words[15:0]));
      chk("ld_overflow", 32'(ld_overflow), 32'(ovf));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic start_load();
    ld_start = 1; step(); ld_start = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic e);
    ld_valid = 1; ld_byte = b; ld_end = e;
    step();
    ld_valid = 0; ld_end = 0;
  endtask

  task automatic end_load();
    ld_end = 1; step(); ld_end = 0;
  endtask

  task automatic fetch(input logic [31:0] a);
    req_valid = 1; req_addr = a; step(); req_valid = 0;
  endtask

  logic [31:0] w_rand [D+1];
  logic [7:0]  plan [8];

  initial begin
    plan[0] = 8'h13; plan[1] = 8'h05; plan[2] = 8'h10; plan[3] = 8'h00;
    plan[4] = 8'h93; plan[5] = 8'h02; plan[6] = 8'h20; plan[7] = 8'h00;

    step(); step();
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_instr", rsp_instr, NOP);
    chk("reset ld_busy", 32'(ld_busy), 32'd0);
    chk("reset ld_words", 32'(ld_words), 32'd0);
    reset = 0;

    // fill the whole memory and wrap by one word, fetch held high
    for (int i = 0; i <= D; i++) w_rand[i] = $urandom;
    start_load();
    req_valid = 1;
    req_addr = 32'h0;
    for (int i = 0; i <= D; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(3) == 0) step();
        send_byte(w_rand[i][8*b +: 8], 1'b0);
      end
    end
    end_load();
    req_valid = 0;
    chk("wrap ld_words", 32'(ld_words), 32'(D + 1));
    chk("wrap ld_overflow", 32'(ld_overflow), 32'd1);
    fetch(32'h0);
    chk("wrap mem0", rsp_instr, w_rand[D]);
    fetch(32'h4);
    chk("wrap mem1", rsp_instr, w_rand[1]);
    fetch(32'(4 * (D - 1)));
    chk("last word", rsp_instr, w_rand[D-1]);
    chk("last word fault", 32'(rsp_fault), 32'd0);

    // directed two-word program
    start_load();
    for (int i = 0; i < 8; i++) send_byte(plan[i], 1'b0);
    end_load();
    chk("plan ld_busy", 32'(ld_busy), 32'd0);
    chk("plan ld_words", 32'(ld_words), 32'd2);
    chk("plan ld_overflow", 32'(ld_overflow), 32'd0);
    req_valid = 1; req_addr = 32'h0; step();
    chk("plan rsp0 valid", 32'(rsp_valid), 32'd1);
    chk("plan rsp0", rsp_instr, 32'h0010_0513);
    req_addr = 32'h4; step();
    chk("plan rsp1 valid", 32'(rsp_valid), 32'd1);
    chk("plan rsp1", rsp_instr, 32'h0020_0293);
    chk("plan rsp1 fault", 32'(rsp_fault), 32'd0);
    req_valid = 0; step();
    chk("plan idle valid", 32'(rsp_valid), 32'd0);

    fetch(32'h2);
    chk("misaligned fault", 32'(rsp_fault), 32'd1);
    chk("misaligned instr", rsp_instr, NOP);
    fetch(32'(D * 4));
    chk("range fault", 32'(rsp_fault), 32'd1);
    chk("range instr", rsp_instr, NOP);

    // partial word ends with the third byte
    start_load();
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b1);
    chk("partial ld_words", 32'(ld_words), 32'd1);
    chk("partial ld_busy", 32'(ld_busy), 32'd0);
    fetch(32'h0);
    chk("partial mem0", rsp_instr, 32'h00CC_BBAA);

    // reset in the middle of the second word
    start_load();
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b0); send_byte(8'h66, 1'b0);
    reset = 1; step(); reset = 0;
    chk("midreset ld_busy", 32'(ld_busy), 32'd0);
    chk("midreset ld_words", 32'(ld_words), 32'd0);
    fetch(32'h0);
    chk("midreset mem0", rsp_instr, 32'h4433_2211);
    fetch(32'h4);
    chk("midreset mem1", rsp_instr, 32'h0020_0293);

    // fetch accepted on the ld_start cycle still responds
    req_valid = 1; req_addr = 32'h4; ld_start = 1; step();
    req_valid = 0; ld_start = 0;
    chk("start fetch valid", 32'(rsp_valid), 32'd1);
    chk("start fetch instr", rsp_instr, 32'h0020_0293);
    end_load();

    for (int c = 0; c < 3000; c++) begin
      int r;
      reset    = ($urandom_range(299) == 0);
      ld_start = ($urandom_range(59) == 0);
      ld_valid = 1'($urandom_range(1));
      ld_byte  = 8'($urandom);
      ld_end   = ($urandom_range(39) == 0);
      req_valid = 1'($urandom_range(1));
      r = $urandom_range(9);
      if (r < 7) req_addr = 32'($urandom_range(D - 1)) << 2;
      else if (r == 7) req_addr = ($urandom & 32'h3FC)
                                  | 32'($urandom_range(3, 1));
      else req_addr = ($urandom & 32'hFFFF_FFFC) | 32'(D * 4);
      step();
    end
    reset = 0; ld_start = 0; ld_valid = 0; ld_end = 0; req_valid = 0;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
